// File: rtl/adau_spi_init.sv
// ADAU1761 SPI init: streams a fixed 14-word command ROM to the codec
// after reset, then raises a sticky done flag.
module adau_spi_init #(
  parameter int CLK_DIV    = 4,
  parameter int GAP_CYCLES = 8
) (
  input  logic clk,
  input  logic reset,
  output logic cdata,
  output logic cclk,
  output logic clatch_n,
  output logic adau_init_done
);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_SEND_BIT = 2'd1;
  localparam logic [1:0] S_GAP      = 2'd2;

  localparam logic [1:0] S_START = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [7:0] DIV_M1  = 8'(CLK_DIV - 1);
  localparam logic [7:0] GAP_M1  = 8'(GAP_CYCLES - 1);
  localparam logic       GAP_ONE = (GAP_CYCLES == 1);
  localparam logic [3:0] LAST_IDX = 4'd13;

  logic [1:0]  ser_st;
  logic        ready;
  logic [31:0] sh;
  logic [7:0]  div_cnt;
  logic [4:0]  bit_cnt;
  logic [7:0]  gap_cnt;

  logic [1:0]  seq_st;
  logic [3:0]  idx;
  logic        command_valid;
  logic        last;
  logic [31:0] word;

  logic xfer;
  logic bit_end;
  logic gap_end;
  logic go_idle;

  // Command ROM: dummy writes first to switch the codec into SPI mode.
  always_comb begin
    word = 32'h0040_0000;
    case (idx)
      4'd0:    word = 32'h0040_0000;
      4'd1:    word = 32'h0040_0000;
      4'd2:    word = 32'h0040_0000;
      4'd3:    word = 32'h0040_0001;
      4'd4:    word = 32'h0040_1501;
      4'd5:    word = 32'h0040_0A01;
      4'd6:    word = 32'h0040_0B05;
      4'd7:    word = 32'h0040_0C01;
      4'd8:    word = 32'h0040_0D05;
      4'd9:    word = 32'h0040_1C21;
      4'd10:   word = 32'h0040_1E41;
      4'd11:   word = 32'h0040_23E7;
      4'd12:   word = 32'h0040_24E7;
      4'd13:   word = 32'h0040_FA01;
      default: word = 32'h0040_0000;
    endcase
  end

  // Handshake and end-of-frame / end-of-gap detection.
  always_comb begin
    xfer    = command_valid && ready && (ser_st == S_IDLE);
    bit_end = (ser_st == S_SEND_BIT) && (div_cnt == DIV_M1)
              && cclk && (bit_cnt == 5'd0);
    gap_end = (ser_st == S_GAP) && (gap_cnt == GAP_M1);
    go_idle = gap_end || (bit_end && GAP_ONE);
  end

  assign cdata = sh[31];

  // Serializer: the idle cycle that accepts the next word counts as the
  // last gap cycle, so clatch_n stays high exactly GAP_CYCLES cycles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ser_st   <= S_IDLE;
      ready    <= 1'b1;
      sh       <= '0;
      cclk     <= 1'b0;
      clatch_n <= 1'b1;
      div_cnt  <= '0;
      bit_cnt  <= '0;
      gap_cnt  <= '0;
    end else begin
      case (ser_st)
        S_IDLE: begin
          if (xfer) begin
            sh       <= word;
            ready    <= 1'b0;
            clatch_n <= 1'b0;
            cclk     <= 1'b0;
            div_cnt  <= '0;
            bit_cnt  <= 5'd31;
            ser_st   <= S_SEND_BIT;
          end
        end
        S_SEND_BIT: begin
          if (div_cnt != DIV_M1) begin
            div_cnt <= div_cnt + 8'd1;
          end else begin
            div_cnt <= '0;
            if (!cclk) begin
              cclk <= 1'b1;
            end else begin
              cclk <= 1'b0;
              if (bit_cnt == 5'd0) begin
                clatch_n <= 1'b1;
                sh       <= '0;
                if (GAP_ONE) begin
                  ser_st <= S_IDLE;
                  ready  <= 1'b1;
                end else begin
                  ser_st  <= S_GAP;
                  gap_cnt <= 8'd1;
                end
              end else begin
                bit_cnt <= bit_cnt - 5'd1;
                sh      <= {sh[30:0], 1'b0};
              end
            end
          end
        end
        S_GAP: begin
          if (gap_cnt == GAP_M1) begin
            ser_st <= S_IDLE;
            ready  <= 1'b1;
          end else begin
            gap_cnt <= gap_cnt + 8'd1;
          end
        end
        default: begin
          ser_st <= S_IDLE;
          ready  <= 1'b1;
        end
      endcase
    end
  end

  // Sequencer: issue one ROM word, wait for its frame and gap, repeat.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      seq_st         <= S_START;
      idx            <= '0;
      command_valid  <= 1'b0;
      last           <= 1'b0;
      adau_init_done <= 1'b0;
    end else begin
      case (seq_st)
        S_START: begin
          command_valid <= 1'b1;
          seq_st        <= S_ISSUE;
        end
        S_ISSUE: begin
          if (xfer) begin
            command_valid <= 1'b0;
            last          <= (idx == LAST_IDX);
            if (idx != LAST_IDX) idx <= idx + 4'd1;
            seq_st <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (go_idle) begin
            if (last) begin
              adau_init_done <= 1'b1;
              seq_st         <= S_DONE;
            end else begin
              command_valid <= 1'b1;
              seq_st        <= S_ISSUE;
            end
          end
        end
        S_DONE: begin
          command_valid <= 1'b0;
        end
        default: seq_st <= S_START;
      endcase
    end
  end

endmodule

// File: tb/tb_adau_spi_init.sv
// Directed bench for adau_spi_init: default timing instance plus a
// CLK_DIV=1 / GAP_CYCLES=1 instance, with a negedge frame monitor.
module tb_adau_spi_init;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0] rst;
  logic cdata_a, cclk_a, cl_a, dn_a;
  logic cdata_b, cclk_b, cl_b, dn_b;
  logic [1:0] cd, ck, cl, dn;

  assign cd = {cdata_b, cdata_a};
  assign ck = {cclk_b, cclk_a};
  assign cl = {cl_b, cl_a};
  assign dn = {dn_b, dn_a};

  adau_spi_init dut_a (
    .clk(clk), .reset(rst[0]), .cdata(cdata_a),
    .cclk(cclk_a), .clatch_n(cl_a), .adau_init_done(dn_a)
  );

  adau_spi_init #(.CLK_DIV(1), .GAP_CYCLES(1)) dut_b (
    .clk(clk), .reset(rst[1]), .cdata(cdata_b),
    .cclk(cclk_b), .clatch_n(cl_b), .adau_init_done(dn_b)
  );

  localparam logic [31:0] EXP [14] = '{
    32'h00400000, 32'h00400000, 32'h00400000, 32'h00400001,
    32'h00401501, 32'h00400A01, 32'h00400B05, 32'h00400C01,
    32'h00400D05, 32'h00401C21, 32'h00401E41, 32'h004023E7,
    32'h004024E7, 32'h0040FA01
  };

  int pass_cnt = 0;
  int total = 0;

  int nfr [2];
  int low [2];
  int hi [2];
  int rise [2];
  int cyc [2];
  int donecyc [2];
  int pdf [2];
  int cbad [2];
  logic [31:0] shv [2];
  logic pc [2];
  logic pl [2];
  logic [31:0] words [2][16];
  int lens [2][16];
  int rises [2][16];
  int gaps [2][16];

  // Frame monitor: captures cdata on cclk rising, measures low/high runs.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (!rst[d]) begin
        nfr[d] = 0; low[d] = 0; hi[d] = 0; rise[d] = 0;
        cyc[d] = 0; donecyc[d] = 0; pdf[d] = 0; cbad[d] = 0;
        shv[d] = '0; pc[d] = 1'b0; pl[d] = 1'b1;
      end else begin
        cyc[d]++;
        if (dn[d] && donecyc[d] == 0) donecyc[d] = cyc[d];
        if (!cl[d]) begin
          if (pl[d]) begin
            if (nfr[d] > 0 && nfr[d] <= 16) gaps[d][nfr[d]-1] = hi[d];
            if (dn[d]) pdf[d]++;
            low[d] = 0; rise[d] = 0; shv[d] = '0;
          end
          low[d]++;
          if (ck[d] && !pc[d]) begin
            shv[d] = {shv[d][30:0], cd[d]};
            rise[d]++;
          end
        end else begin
          if (!pl[d]) begin
            if (nfr[d] < 16) begin
              words[d][nfr[d]] = shv[d];
              lens[d][nfr[d]] = low[d];
              rises[d][nfr[d]] = rise[d];
            end
            nfr[d]++;
            hi[d] = 0;
          end
          hi[d]++;
          if (ck[d]) cbad[d]++;
        end
        pc[d] = ck[d];
        pl[d] = cl[d];
      end
    end
  end

  task automatic test_reset();
    rst = 2'b00;
    repeat (2) begin
      @(negedge clk); #1;
      total++;
      if (cd !== 2'b00) $display("FAIL rst_cdata: got %b want 00", cd);
      else pass_cnt++;
      total++;
      if (ck !== 2'b00) $display("FAIL rst_cclk: got %b want 00", ck);
      else pass_cnt++;
      total++;
      if (cl !== 2'b11) $display("FAIL rst_clatch_n: got %b want 11", cl);
      else pass_cnt++;
      total++;
      if (dn !== 2'b00) $display("FAIL rst_done: got %b want 00", dn);
      else pass_cnt++;
    end
  endtask

  task automatic test_first_frame();
    int n = 0;
    rst[0] = 1'b1;
    while (nfr[0] < 1 && n < 400) begin @(negedge clk); #1; n++; end
    total++;
    if (nfr[0] < 1) $display("FAIL first_frame_timeout: frames=%0d want 1", nfr[0]);
    else pass_cnt++;
    total++;
    if (lens[0][0] != 256) $display("FAIL first_len: got %0d want 256", lens[0][0]);
    else pass_cnt++;
    total++;
    if (rises[0][0] != 32) $display("FAIL first_rises: got %0d want 32", rises[0][0]);
    else pass_cnt++;
    total++;
    if (words[0][0] !== 32'h00400000)
      $display("FAIL first_word: got %h want 00400000", words[0][0]);
    else pass_cnt++;
  endtask

  task automatic test_sequence(input int d, input int flen, input int gap,
                               input int dlo, input int dhi);
    int n = 0;
    while (dn[d] !== 1'b1 && n < 5000) begin @(negedge clk); #1; n++; end
    total++;
    if (dn[d] !== 1'b1) $display("FAIL seq%0d_done_timeout: got %b want 1", d, dn[d]);
    else pass_cnt++;
    total++;
    if (nfr[d] != 14) $display("FAIL seq%0d_frames: got %0d want 14", d, nfr[d]);
    else pass_cnt++;
    for (int i = 0; i < 14; i++) begin
      total++;
      if (words[d][i] !== EXP[i])
        $display("FAIL seq%0d_word%0d: got %h want %h", d, i, words[d][i], EXP[i]);
      else pass_cnt++;
      total++;
      if (lens[d][i] != flen)
        $display("FAIL seq%0d_len%0d: got %0d want %0d", d, i, lens[d][i], flen);
      else pass_cnt++;
      total++;
      if (rises[d][i] != 32)
        $display("FAIL seq%0d_rises%0d: got %0d want 32", d, i, rises[d][i]);
      else pass_cnt++;
      if (i < 13) begin
        total++;
        if (gaps[d][i] != gap)
          $display("FAIL seq%0d_gap%0d: got %0d want %0d", d, i, gaps[d][i], gap);
        else pass_cnt++;
      end
    end
    total++;
    if (donecyc[d] < dlo || donecyc[d] > dhi)
      $display("FAIL seq%0d_done_cycle: got %0d want %0d..%0d", d, donecyc[d], dlo, dhi);
    else pass_cnt++;
    total++;
    if (cbad[d] != 0) $display("FAIL seq%0d_cclk_idle: got %0d want 0", d, cbad[d]);
    else pass_cnt++;
  endtask

  task automatic test_done_sticky();
    repeat (2000) @(negedge clk);
    #1;
    total++;
    if (dn[0] !== 1'b1) $display("FAIL sticky_done: got %b want 1", dn[0]);
    else pass_cnt++;
    total++;
    if (pdf[0] != 0) $display("FAIL post_done_frames: got %0d want 0", pdf[0]);
    else pass_cnt++;
    total++;
    if (nfr[0] != 14) $display("FAIL post_done_count: got %0d want 14", nfr[0]);
    else pass_cnt++;
  endtask

  task automatic test_abort();
    int n = 0;
    rst[0] = 1'b0;
    repeat (2) @(negedge clk);
    #1 rst[0] = 1'b1;
    while (!(nfr[0] == 5 && rise[0] == 10 && cl[0] == 1'b0) && n < 3000) begin
      @(negedge clk); #1; n++;
    end
    total++;
    if (nfr[0] != 5 || rise[0] != 10)
      $display("FAIL abort_reach: got frame %0d bit %0d want 5/10", nfr[0], rise[0]);
    else pass_cnt++;
    total++;
    if (cl[0] !== 1'b0 || ck[0] !== 1'b1)
      $display("FAIL abort_pre: got clatch_n=%b cclk=%b want 0/1", cl[0], ck[0]);
    else pass_cnt++;
    rst[0] = 1'b0;
    #1;
    total++;
    if (cl[0] !== 1'b1 || ck[0] !== 1'b0 || cd[0] !== 1'b0)
      $display("FAIL abort_async: got clatch_n=%b cclk=%b cdata=%b want 1/0/0",
               cl[0], ck[0], cd[0]);
    else pass_cnt++;
    @(negedge clk);
    @(negedge clk);
    #1 rst[0] = 1'b1;
    test_sequence(0, 256, 8, 3694, 3700);
  endtask

  task automatic test_rerun_after_done();
    rst[0] = 1'b0;
    #1;
    total++;
    if (dn[0] !== 1'b0) $display("FAIL rerun_clear: got %b want 0", dn[0]);
    else pass_cnt++;
    @(negedge clk);
    @(negedge clk);
    #1 rst[0] = 1'b1;
    test_sequence(0, 256, 8, 3694, 3700);
  endtask

  task automatic test_fast();
    rst[1] = 1'b1;
    test_sequence(1, 64, 1, 908, 914);
  endtask

  initial begin
    rst = 2'b00;
    test_reset();
    test_first_frame();
    test_sequence(0, 256, 8, 3694, 3700);
    test_done_sticky();
    test_abort();
    test_rerun_after_done();
    test_fast();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
